axis_stream_link: RTL and testbench
===================================

// Module: axis_stream_link
// PURPOSE
//  AXI4-Stream point-to-point link between one master port (s_*) and one slave port (m_*).
//  - Forwards every beat in order through a 2-entry fully registered skid buffer.
//  - Classifies each packet (beats up to and including TLAST) as aligned, sparse or unaligned.
//  - Counts beats, packets per class and protocol errors for end-of-test reporting.
//  - Sits between the stream master agent interface and the stream slave agent interface.
// PARAMETERS
//  DATA_BYTES  4   TDATA width in bytes (TSTRB/TKEEP width)
//  ID_W        4   TID width
//  DEST_W      4   TDEST width
//  USER_W      8   TUSER width
//  CNT_W       16  width of every statistics counter
// PORTS
//  ACLK           in   1             clock, all logic on rising edge
//  ARESET         in   1             synchronous, active-high reset
//  s_tvalid       in   1             upstream beat valid
//  s_tready       out  1             link can accept a beat
//  s_tdata        in   8*DATA_BYTES  upstream data
//  s_tstrb        in   DATA_BYTES    byte qualifier: data(1) / position(0)
//  s_tkeep        in   DATA_BYTES    byte qualifier: kept(1) / null(0)
//  s_tlast        in   1             last beat of packet
//  s_tid/s_tdest/s_tuser  in  ID_W/DEST_W/USER_W  sideband, carried unchanged
//  m_tvalid, m_tdata, m_tstrb, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser  out  same widths  downstream beat
//  m_tready       in   1             downstream accepts
//  beat_cnt, aligned_cnt, sparse_cnt, unaligned_cnt, err_cnt  out  CNT_W each  statistics
// BEHAVIOUR
//  Reset (ARESET=1 at an edge): buffer empties; m_tvalid=0, s_tready=0 while ARESET high, all counters 0, packet-class state cleared.
//  - Mid-packet reset drops buffered beats; the partial packet is never counted.
//  Handshake: a beat transfers on any edge with valid&&ready on that port.
//  Buffer:
//  - s_tready = !ARESET && (occupancy<2); occupancy is a register, so s_tready has no path from m_tready.
//  - Latency: beat accepted at edge N appears on m_* after edge N (1 cycle) when the buffer was empty.
//  - Push and pop in the same cycle leave occupancy unchanged.
//  - FIFO order is preserved; all payload fields are carried bit-exact.
//  - m_* payload is stable while m_tvalid=1 and m_tready=0.
//  - m_tvalid never drops without a handshake.
//  Byte types per lane: keep=1,strb=1 data; keep=1,strb=0 position; keep=0,strb=0 null; keep=0,strb=1 illegal.
//  Packet class, taken over all accepted beats of the packet, priority top-down:
//  - unaligned: any beat has a null byte (tkeep != all-ones).
//  - sparse: every tkeep all-ones, but any tstrb bit 0.
//  - aligned: every byte of every beat is a data byte.
//  - The class of the accumulated beats is resolved at the s-side handshake of the TLAST beat; the matching counter increments at that edge.
//  - Accumulator clears for the next packet in the same edge.
//  beat_cnt: +1 per s-side handshake.
//  err_cnt: +1 per accepted beat containing any illegal lane.
//  - Illegal beats are still forwarded and still classified; treat illegal lanes as null.
//  - Also +1 on any cycle where s_tvalid was 1 and s_tready 0 on the previous cycle, and now s_tvalid=0 or the payload changed.
//  - Both error events in one cycle add 2.
//  All counters saturate at 2^CNT_W-1 and never wrap.
// TESTING
//  1. Reset, then 3-beat packet with keep=strb=4'hF, m_tready=1:
//     -> beats exit 1 cycle after entry, same order; beat_cnt=3, aligned_cnt=1.
//  2. Beat 2 of a 2-beat packet has tstrb=4'hB, tkeep=4'hF:
//     -> sparse_cnt=1, aligned_cnt unchanged.
//  3. Last beat has tkeep=4'h3, tstrb=4'h3:
//     -> unaligned_cnt=1; a packet mixing null and position bytes also counts as unaligned only.
//  4. m_tready=0 for 5 cycles with s_tvalid=1:
//     -> exactly 2 beats are accepted, s_tready=0 afterwards, m_* held stable.
//     -> after m_tready=1 the stream drains with no loss or duplication.
//  5. Lane with tkeep=0, tstrb=1 (err_cnt+1).
//     Separately, drop s_tvalid while stalled (err_cnt+1) -> err_cnt=2.
//  6. Assert ARESET for 10 cycles after beat 2 of a 4-beat packet:
//     -> m_tvalid=0, all counters 0.
//     -> the next full aligned packet gives aligned_cnt=1.

Source files
------------

// File: rtl/axis_stream_link.sv
// AXI4-Stream link: 2-entry registered skid buffer with per-packet class
// statistics (aligned / sparse / unaligned), beat counting and protocol-error counting.

module axis_lane_type (
    input  logic keep,
    input  logic strb,
    output logic is_null,
    output logic is_pos,
    output logic is_ill
);
    // An illegal lane (keep=0, strb=1) is classified as null.
    assign is_null = !keep;
    assign is_pos  = keep && !strb;
    assign is_ill  = !keep && strb;
endmodule

module axis_stream_link #(
    parameter int DATA_BYTES = 4,
    parameter int ID_W       = 4,
    parameter int DEST_W     = 4,
    parameter int USER_W     = 8,
    parameter int CNT_W      = 16
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic                    s_tvalid,
    output logic                    s_tready,
    input  logic [8*DATA_BYTES-1:0] s_tdata,
    input  logic [DATA_BYTES-1:0]   s_tstrb,
    input  logic [DATA_BYTES-1:0]   s_tkeep,
    input  logic                    s_tlast,
    input  logic [ID_W-1:0]         s_tid,
    input  logic [DEST_W-1:0]       s_tdest,
    input  logic [USER_W-1:0]       s_tuser,
    output logic                    m_tvalid,
    input  logic                    m_tready,
    output logic [8*DATA_BYTES-1:0] m_tdata,
    output logic [DATA_BYTES-1:0]   m_tstrb,
    output logic [DATA_BYTES-1:0]   m_tkeep,
    output logic                    m_tlast,
    output logic [ID_W-1:0]         m_tid,
    output logic [DEST_W-1:0]       m_tdest,
    output logic [USER_W-1:0]       m_tuser,
    output logic [CNT_W-1:0]        beat_cnt,
    output logic [CNT_W-1:0]        aligned_cnt,
    output logic [CNT_W-1:0]        sparse_cnt,
    output logic [CNT_W-1:0]        unaligned_cnt,
    output logic [CNT_W-1:0]        err_cnt
);
    typedef struct packed {
        logic [8*DATA_BYTES-1:0] data;
        logic [DATA_BYTES-1:0]   strb;
        logic [DATA_BYTES-1:0]   keep;
        logic                    last;
        logic [ID_W-1:0]         id;
        logic [DEST_W-1:0]       dest;
        logic [USER_W-1:0]       user;
    } beat_t;

    beat_t in_beat, out_q, skid_q, prev_q;
    logic [1:0] occ;
    logic push, pop;
    logic [DATA_BYTES-1:0] lane_null, lane_pos, lane_ill;
    logic acc_null, acc_pos, pkt_null, pkt_pos;
    logic stall_q, stall_err, ill_err;
    logic [1:0] err_inc;

    assign in_beat = '{data: s_tdata, strb: s_tstrb, keep: s_tkeep, last: s_tlast,
                       id: s_tid, dest: s_tdest, user: s_tuser};

    assign s_tready = !ARESET && (occ != 2'd2);
    assign m_tvalid = (occ != 2'd0);
    assign push     = s_tvalid && s_tready;
    assign pop      = m_tvalid && m_tready;

    assign m_tdata = out_q.data;
    assign m_tstrb = out_q.strb;
    assign m_tkeep = out_q.keep;
    assign m_tlast = out_q.last;
    assign m_tid   = out_q.id;
    assign m_tdest = out_q.dest;
    assign m_tuser = out_q.user;

    axis_lane_type u_lane [DATA_BYTES-1:0] (
        .keep   (s_tkeep),
        .strb   (s_tstrb),
        .is_null(lane_null),
        .is_pos (lane_pos),
        .is_ill (lane_ill)
    );

    // Class flags including the beat being accepted this cycle.
    assign pkt_null  = acc_null || (|lane_null);
    assign pkt_pos   = acc_pos  || (|lane_pos);
    assign stall_err = stall_q && (!s_tvalid || (in_beat != prev_q));
    assign ill_err   = push && (|lane_ill);
    assign err_inc   = {1'b0, stall_err} + {1'b0, ill_err};

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c,
                                                 input logic [1:0] inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, c} + {{(CNT_W-1){1'b0}}, inc};
        return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    endfunction

    // out_q always holds the oldest beat; skid_q only fills when out_q is stalled.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            occ <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
            if (push && (occ == 2'd0 || pop))
                out_q <= in_beat;
            else if (push)
                skid_q <= in_beat;
            else if (pop && occ == 2'd2)
                out_q <= skid_q;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            acc_null      <= 1'b0;
            acc_pos       <= 1'b0;
            stall_q       <= 1'b0;
            prev_q        <= '0;
            beat_cnt      <= '0;
            aligned_cnt   <= '0;
            sparse_cnt    <= '0;
            unaligned_cnt <= '0;
            err_cnt       <= '0;
        end else begin
            stall_q <= s_tvalid && !s_tready;
            prev_q  <= in_beat;
            err_cnt <= sat_add(err_cnt, err_inc);
            if (push) begin
                beat_cnt <= sat_add(beat_cnt, 2'd1);
                if (s_tlast) begin
                    acc_null <= 1'b0;
                    acc_pos  <= 1'b0;
                    if (pkt_null)
                        unaligned_cnt <= sat_add(unaligned_cnt, 2'd1);
                    else if (pkt_pos)
                        sparse_cnt <= sat_add(sparse_cnt, 2'd1);
                    else
                        aligned_cnt <= sat_add(aligned_cnt, 2'd1);
                end else begin
                    acc_null <= pkt_null;
                    acc_pos  <= pkt_pos;
                end
            end
        end
    end
endmodule

// File: tb/tb_axis_stream_link.sv
// Bench for axis_stream_link: directed scenarios plus a randomized stream,
// checked against a queue-based reference model of the link.

module tb_axis_stream_link;
    localparam int DB = 4, IW = 4, DW = 4, UW = 8, CW = 6;
    localparam int MAXC = (1 << CW) - 1;

    typedef struct packed {
        logic [8*DB-1:0] data;
        logic [DB-1:0]   strb;
        logic [DB-1:0]   keep;
        logic            last;
        logic [IW-1:0]   id;
        logic [DW-1:0]   dest;
        logic [UW-1:0]   user;
    } beat_t;

    logic ACLK = 1'b0, ARESET = 1'b1;
    logic s_tvalid = 1'b0, s_tready, s_tlast = 1'b0;
    logic [8*DB-1:0] s_tdata = '0;
    logic [DB-1:0] s_tstrb = '0, s_tkeep = '0;
    logic [IW-1:0] s_tid = '0;
    logic [DW-1:0] s_tdest = '0;
    logic [UW-1:0] s_tuser = '0;
    logic m_tvalid, m_tready = 1'b0, m_tlast;
    logic [8*DB-1:0] m_tdata;
    logic [DB-1:0] m_tstrb, m_tkeep;
    logic [IW-1:0] m_tid;
    logic [DW-1:0] m_tdest;
    logic [UW-1:0] m_tuser;
    logic [CW-1:0] beat_cnt, aligned_cnt, sparse_cnt, unaligned_cnt, err_cnt;

    always #5 ACLK = ~ACLK;

    axis_stream_link #(.DATA_BYTES(DB), .ID_W(IW), .DEST_W(DW), .USER_W(UW), .CNT_W(CW)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tstrb(s_tstrb),
        .s_tkeep(s_tkeep), .s_tlast(s_tlast), .s_tid(s_tid), .s_tdest(s_tdest), .s_tuser(s_tuser),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tstrb(m_tstrb),
        .m_tkeep(m_tkeep), .m_tlast(m_tlast), .m_tid(m_tid), .m_tdest(m_tdest), .m_tuser(m_tuser),
        .beat_cnt(beat_cnt), .aligned_cnt(aligned_cnt), .sparse_cnt(sparse_cnt),
        .unaligned_cnt(unaligned_cnt), .err_cnt(err_cnt)
    );

    beat_t s_pl, m_pl;
    assign s_pl = '{data: s_tdata, strb: s_tstrb, keep: s_tkeep, last: s_tlast,
                    id: s_tid, dest: s_tdest, user: s_tuser};
    assign m_pl = '{data: m_tdata, strb: m_tstrb, keep: m_tkeep, last: m_tlast,
                    id: m_tid, dest: m_tdest, user: m_tuser};

    int checks = 0, errors = 0;

    // Reference model: values predicted for the upcoming clock edge, sampled mid-cycle.
    beat_t exp_q[$];
    beat_t pkt[$];
    int m_beat = 0, m_al = 0, m_sp = 0, m_un = 0, m_err = 0, raw_beats = 0;
    int mon_bad = 0, hold_bad = 0;
    bit prev_stall = 0, prev_mstall = 0, any_null, any_pos;
    beat_t prev_spl, prev_mpl;

    function automatic int sat(input int v);
        return (v > MAXC) ? MAXC : v;
    endfunction

    always @(negedge ACLK) begin
        if (ARESET) begin
            exp_q.delete();
            pkt.delete();
            m_beat = 0; m_al = 0; m_sp = 0; m_un = 0; m_err = 0; raw_beats = 0;
            prev_stall = 0; prev_mstall = 0;
        end else begin
            if (prev_mstall && (m_tvalid !== 1'b1 || m_pl !== prev_mpl)) hold_bad++;
            prev_mstall = m_tvalid && !m_tready;
            prev_mpl = m_pl;
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) mon_bad++;
                else begin
                    if (exp_q[0] !== m_pl) mon_bad++;
                    void'(exp_q.pop_front());
                end
            end
            if (prev_stall && (!s_tvalid || s_pl != prev_spl)) m_err = sat(m_err + 1);
            prev_stall = s_tvalid && !s_tready;
            prev_spl = s_pl;
            if (s_tvalid && s_tready) begin
                exp_q.push_back(s_pl);
                pkt.push_back(s_pl);
                m_beat = sat(m_beat + 1);
                raw_beats++;
                if ((~s_tkeep & s_tstrb) != '0) m_err = sat(m_err + 1);
                if (s_tlast) begin
                    any_null = 0; any_pos = 0;
                    foreach (pkt[k]) begin
                        if (pkt[k].keep != '1) any_null = 1;
                        if (pkt[k].strb != '1) any_pos = 1;
                    end
                    if (any_null) m_un = sat(m_un + 1);
                    else if (any_pos) m_sp = sat(m_sp + 1);
                    else m_al = sat(m_al + 1);
                    pkt.delete();
                end
            end
        end
    end

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    function automatic beat_t mk(input logic [DB-1:0] keep, input logic [DB-1:0] strb,
                                 input logic last);
        beat_t b;
        b.data = $urandom;
        b.strb = strb;
        b.keep = keep;
        b.last = last;
        b.id   = IW'($urandom);
        b.dest = DW'($urandom);
        b.user = UW'($urandom);
        return b;
    endfunction

    function automatic beat_t rnd_beat();
        logic [DB-1:0] k, s;
        k = ($urandom_range(9, 0) < 6) ? '1 : DB'($urandom);
        s = (k == '1 && $urandom_range(1, 0) == 1) ? '1 : DB'($urandom);
        return mk(k, s, ($urandom_range(3, 0) == 0));
    endfunction

    task automatic set_pl(input beat_t b);
        s_tdata = b.data; s_tstrb = b.strb; s_tkeep = b.keep; s_tlast = b.last;
        s_tid = b.id; s_tdest = b.dest; s_tuser = b.user;
    endtask

    // Presents a beat and returns just after the edge that accepts it.
    task automatic drive_beat(input beat_t b);
        bit a;
        a = 0;
        set_pl(b);
        s_tvalid = 1'b1;
        for (int n = 0; n < 50 && !a; n++) begin
            @(negedge ACLK);
            a = s_tready;
            tick();
        end
        if (!a) begin
            checks++; errors++;
            $display("FAIL drive_timeout: beat not accepted within 50 cycles, required acceptance");
        end
    endtask

    task automatic settle();
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        repeat (4) tick();
    endtask

    task automatic do_reset(input int n);
        ARESET = 1'b1;
        s_tvalid = 1'b0;
        repeat (n) tick();
        ARESET = 1'b0;
    endtask

    task automatic test_reset();
        ARESET = 1'b1; s_tvalid = 1'b0; m_tready = 1'b1;
        repeat (3) tick();
        checks++;
        if (m_tvalid !== 1'b0 || s_tready !== 1'b0) begin
            errors++;
            $display("FAIL reset_handshake: m_tvalid=%b s_tready=%b, required 0 0", m_tvalid, s_tready);
        end
        checks++;
        if ({beat_cnt, aligned_cnt, sparse_cnt, unaligned_cnt, err_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_counters: %0d %0d %0d %0d %0d, required all 0",
                     beat_cnt, aligned_cnt, sparse_cnt, unaligned_cnt, err_cnt);
        end
        ARESET = 1'b0;
        tick();
        checks++;
        if (s_tready !== 1'b1 || m_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset: s_tready=%b m_tvalid=%b, required 1 0", s_tready, m_tvalid);
        end
    endtask

    task automatic test_aligned();
        beat_t b[3];
        for (int i = 0; i < 3; i++) b[i] = mk(4'hF, 4'hF, i == 2);
        m_tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_beat(b[i]);
            checks++;
            if (m_tvalid !== 1'b1 || m_pl !== b[i]) begin
                errors++;
                $display("FAIL latency_beat%0d: m_tvalid=%b m=%h, required 1 %h", i, m_tvalid, m_pl, b[i]);
            end
        end
        settle();
        checks++;
        if (beat_cnt !== 6'd3 || aligned_cnt !== 6'd1 || beat_cnt !== CW'(m_beat)) begin
            errors++;
            $display("FAIL aligned_counts: beat=%0d aligned=%0d, required 3 1", beat_cnt, aligned_cnt);
        end
        checks++;
        if (mon_bad != 0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL aligned_order: bad=%0d pending=%0d, required 0 0", mon_bad, exp_q.size());
        end
    endtask

    task automatic test_sparse();
        m_tready = 1'b1;
        drive_beat(mk(4'hF, 4'hF, 1'b0));
        drive_beat(mk(4'hF, 4'hB, 1'b1));
        settle();
        checks++;
        if (sparse_cnt !== CW'(m_sp) || aligned_cnt !== CW'(m_al) || sparse_cnt !== 6'd1) begin
            errors++;
            $display("FAIL sparse_class: sparse=%0d aligned=%0d, required %0d %0d", sparse_cnt, aligned_cnt, m_sp, m_al);
        end
    endtask

    task automatic test_unaligned();
        m_tready = 1'b1;
        drive_beat(mk(4'hF, 4'hF, 1'b0));
        drive_beat(mk(4'h3, 4'h3, 1'b1));
        drive_beat(mk(4'hF, 4'hE, 1'b0));
        drive_beat(mk(4'h7, 4'h7, 1'b1));
        settle();
        checks++;
        if (unaligned_cnt !== CW'(m_un) || unaligned_cnt !== 6'd2) begin
            errors++;
            $display("FAIL unaligned_class: unaligned=%0d, required %0d", unaligned_cnt, m_un);
        end
        checks++;
        if (sparse_cnt !== CW'(m_sp) || aligned_cnt !== CW'(m_al)) begin
            errors++;
            $display("FAIL unaligned_others: sparse=%0d aligned=%0d, required %0d %0d", sparse_cnt, aligned_cnt, m_sp, m_al);
        end
    endtask

    task automatic test_stall();
        beat_t b[4];
        int idx;
        bit a;
        for (int i = 0; i < 4; i++) b[i] = mk(4'hF, 4'hF, i == 3);
        m_tready = 1'b0;
        idx = 0;
        set_pl(b[0]);
        s_tvalid = 1'b1;
        repeat (5) begin
            @(negedge ACLK);
            a = s_tready;
            tick();
            if (a) begin idx++; set_pl(b[idx]); end
        end
        checks++;
        if (idx != 2 || s_tready !== 1'b0) begin
            errors++;
            $display("FAIL stall_accept: accepted=%0d s_tready=%b, required 2 0", idx, s_tready);
        end
        checks++;
        if (m_tvalid !== 1'b1 || m_pl !== b[0]) begin
            errors++;
            $display("FAIL stall_head: m_tvalid=%b m=%h, required 1 %h", m_tvalid, m_pl, b[0]);
        end
        m_tready = 1'b1;
        drive_beat(b[2]);
        drive_beat(b[3]);
        settle();
        checks++;
        if (mon_bad != 0 || hold_bad != 0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL stall_drain: bad=%0d hold=%0d pending=%0d, required 0 0 0", mon_bad, hold_bad, exp_q.size());
        end
        checks++;
        if (beat_cnt !== CW'(m_beat) || err_cnt !== CW'(m_err)) begin
            errors++;
            $display("FAIL stall_counts: beat=%0d err=%0d, required %0d %0d", beat_cnt, err_cnt, m_beat, m_err);
        end
    endtask

    task automatic test_errors();
        do_reset(2);
        m_tready = 1'b1;
        drive_beat(mk(4'hE, 4'h1, 1'b1));
        settle();
        checks++;
        if (err_cnt !== 6'd1 || unaligned_cnt !== CW'(m_un)) begin
            errors++;
            $display("FAIL err_illegal: err=%0d unaligned=%0d, required 1 %0d", err_cnt, unaligned_cnt, m_un);
        end
        m_tready = 1'b0;
        drive_beat(mk(4'hF, 4'hF, 1'b0));
        drive_beat(mk(4'hF, 4'hF, 1'b1));
        set_pl(mk(4'hF, 4'hF, 1'b0));
        s_tvalid = 1'b1;
        repeat (2) tick();
        s_tvalid = 1'b0;
        tick();
        settle();
        checks++;
        if (err_cnt !== 6'd2 || err_cnt !== CW'(m_err)) begin
            errors++;
            $display("FAIL err_drop: err=%0d, required 2 (model %0d)", err_cnt, m_err);
        end
    endtask

    task automatic test_mid_reset();
        m_tready = 1'b0;
        drive_beat(mk(4'hF, 4'hF, 1'b0));
        drive_beat(mk(4'hF, 4'hF, 1'b0));
        do_reset(10);
        checks++;
        if (m_tvalid !== 1'b0 || {beat_cnt, aligned_cnt, sparse_cnt, unaligned_cnt, err_cnt} !== '0) begin
            errors++;
            $display("FAIL midreset_clear: m_tvalid=%b beat=%0d err=%0d, required 0 0 0", m_tvalid, beat_cnt, err_cnt);
        end
        m_tready = 1'b1;
        for (int i = 0; i < 4; i++) drive_beat(mk(4'hF, 4'hF, i == 3));
        settle();
        checks++;
        if (aligned_cnt !== 6'd1 || beat_cnt !== 6'd4 || unaligned_cnt !== 6'd0) begin
            errors++;
            $display("FAIL midreset_next: aligned=%0d beat=%0d unaligned=%0d, required 1 4 0", aligned_cnt, beat_cnt, unaligned_cnt);
        end
        checks++;
        if (mon_bad != 0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL midreset_order: bad=%0d pending=%0d, required 0 0", mon_bad, exp_q.size());
        end
    endtask

    task automatic test_random();
        bit a;
        do_reset(2);
        for (int c = 0; c < 800; c++) begin
            m_tready = ($urandom_range(3, 0) != 0);
            if (!s_tvalid) begin
                if ($urandom_range(2, 0) != 0) begin set_pl(rnd_beat()); s_tvalid = 1'b1; end
            end else if ($urandom_range(15, 0) == 0) begin
                if ($urandom_range(1, 0) == 1) s_tvalid = 1'b0;
                else set_pl(rnd_beat());
            end
            @(negedge ACLK);
            a = s_tvalid && s_tready;
            tick();
            if (a) s_tvalid = 1'b0;
        end
        settle();
        checks++;
        if (beat_cnt !== CW'(m_beat) || aligned_cnt !== CW'(m_al) || sparse_cnt !== CW'(m_sp) ||
            unaligned_cnt !== CW'(m_un) || err_cnt !== CW'(m_err)) begin
            errors++;
            $display("FAIL random_counts: %0d %0d %0d %0d %0d, required %0d %0d %0d %0d %0d",
                     beat_cnt, aligned_cnt, sparse_cnt, unaligned_cnt, err_cnt, m_beat, m_al, m_sp, m_un, m_err);
        end
        checks++;
        if (mon_bad != 0 || hold_bad != 0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL random_stream: bad=%0d hold=%0d pending=%0d, required 0 0 0", mon_bad, hold_bad, exp_q.size());
        end
        if (raw_beats >= MAXC) begin
            checks++;
            if (beat_cnt !== CW'(MAXC)) begin
                errors++;
                $display("FAIL beat_saturate: beat=%0d after %0d beats, required %0d", beat_cnt, raw_beats, MAXC);
            end
        end
    endtask

    initial begin
        test_reset();
        test_aligned();
        test_sparse();
        test_unaligned();
        test_stall();
        test_errors();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule
